pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_ADDR, default 32'h00000000, first fetch address after reset.
REQ-002 The block SHALL have parameter TRAP_VECTOR, default 32'h00000100, fetch address on trap or misaligned redirect.
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 o_imem_req  output  1  instruction fetch request.
REQ-006 o_imem_addr  output  32  fetch address, word-aligned.
REQ-007 i_imem_gnt  input  1  memory accepts request this cycle.
REQ-008 i_imem_rvalid  input  1  fetch response valid.
REQ-009 i_imem_rdata  input  32  fetched instruction.
REQ-010 o_inst_valid  output  1  instruction presented to decode.
REQ-011 o_inst  output  32  held instruction.
REQ-012 o_inst_pc  output  32  address of o_inst.
REQ-013 i_dec_ready  input  1  decode consumes instruction when high with o_inst_valid.
REQ-014 i_redirect  input  1  branch/jump taken, one-cycle pulse.
REQ-015 i_redirect_target  input  32  redirect address.
REQ-016 i_trap  input  1  exception/interrupt, one-cycle pulse.
REQ-017 i_halt  input  1  level; stop fetching.
REQ-018 o_misaligned  output  1  one-cycle pulse on redirect target with bits[1:0] != 0.
REQ-019 o_halted  output  1  high while in HALT.

Function
REQ-020 The block SHALL implement states IDLE, REQ, WAIT, HOLD, HALT, and keep an internal 32-bit fetch PC.
REQ-021 IDLE lasts exactly one cycle after reset, then goes to REQ.
REQ-022 REQ: o_imem_req=1, o_imem_addr=fetch PC; on i_imem_gnt go to WAIT.
REQ-023 WAIT: o_imem_req=0; on i_imem_rvalid latch i_imem_rdata to o_inst and fetch PC to o_inst_pc, go to HOLD.
REQ-024 HOLD: o_inst_valid=1, o_inst/o_inst_pc stable; on i_dec_ready, fetch PC += 4 (mod 2^32, wrap 32'hFFFFFFFC -> 0), go to REQ, or HALT if i_halt=1.
REQ-025 At most one request outstanding; no new request while in WAIT or HOLD.
REQ-026 Control priority each cycle: i_trap > i_redirect > i_halt > sequential.
REQ-027 i_trap in any non-HALT or HALT state: fetch PC <= TRAP_VECTOR, o_inst_valid=0 next cycle, next state REQ, except WAIT (REQ-030).
REQ-028 i_redirect with aligned target: as REQ-027 using i_redirect_target.
REQ-029 i_redirect with misaligned target: o_misaligned=1 next cycle, handled as trap to TRAP_VECTOR.
REQ-030 Trap/redirect in WAIT: set kill flag, stay WAIT; next rvalid (incl. same-cycle rvalid) discarded, then REQ at new PC.
REQ-031 Trap/redirect in REQ without grant: o_imem_addr changes to new PC next cycle, request stays asserted; with same-cycle grant, treated as WAIT case (kill).
REQ-032 Trap/redirect in HOLD with same-cycle i_dec_ready: instruction counts as consumed; PC takes new target, not +4.
REQ-033 i_halt only takes effect at HOLD handoff or in REQ before grant; HALT exits only on i_trap or i_redirect.
REQ-034 Fetch latency: address to o_inst_valid = gnt cycle + rvalid cycle + 1 register cycle.

Reset
REQ-035 During i_rst: state IDLE, fetch PC=RESET_ADDR, o_imem_req=0, o_inst_valid=0, o_inst=0, o_inst_pc=0, o_misaligned=0, o_halted=0, kill flag=0.
REQ-036 Reset mid-operation SHALL abandon any outstanding request; a late rvalid after reset while in IDLE/REQ SHALL be ignored.

Verification
REQ-037 Reset, gnt and rvalid 1 cycle after req, dec_ready=1 -> addresses 0x0, 0x4, 0x8 issued; o_inst_pc tracks.
REQ-038 Redirect to 0x200 while in WAIT, rvalid arrives same cycle -> response discarded, next req addr 0x200, no o_inst_valid for old fetch.
REQ-039 Redirect to 0x203 -> o_misaligned pulse, next req addr 0x100.
REQ-040 HOLD with dec_ready=0 for 5 cycles -> o_inst stable, no o_imem_req; then dec_ready=1 -> next req at PC+4.
REQ-041 i_halt=1 at handoff -> o_halted=1, no requests; i_trap -> req at 0x100, o_halted=0.
REQ-042 Fetch PC 0xFFFFFFFC consumed -> next req addr 0x00000000; i_rst in WAIT -> IDLE, then req at RESET_ADDR.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-fetch sequencer.
// Keeps one instruction request in flight at a time and holds each returned
// instruction for decode until it is consumed. Trap and redirect events
// re-steer the fetch PC. A fetch that is in flight when it is re-steered is
// marked killed, and its response is dropped when it arrives.
module pc_sequencer #(
    parameter logic [31:0] RESET_ADDR  = 32'h00000000,
    parameter logic [31:0] TRAP_VECTOR = 32'h00000100
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_dec_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_target,
    input  logic        i_trap,
    input  logic        i_halt,
    output logic        o_misaligned,
    output logic        o_halted
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_kill;
    logic        w_kill_nxt;
    logic        w_latch;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_misaligned;

    logic        w_target_misaligned;
    logic        w_ctl;
    logic        w_mis_evt;
    logic [31:0] w_ctl_pc;

    // A trap outranks a redirect. A misaligned redirect is steered to the trap vector.
    assign w_target_misaligned = (i_redirect_target[1:0] != 2'b00);
    assign w_ctl               = i_trap | i_redirect;
    assign w_mis_evt           = ~i_trap & i_redirect & w_target_misaligned;
    assign w_ctl_pc            = (i_trap | w_target_misaligned) ? TRAP_VECTOR : i_redirect_target;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, next-PC and kill-flag decision with priority trap > redirect > halt > sequential
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_kill_nxt  = r_kill;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ctl) begin
                    w_pc_nxt = w_ctl_pc;
                end else begin
                    w_pc_nxt = r_pc;
                end
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (w_ctl) begin
                    w_pc_nxt = w_ctl_pc;
                    if (i_imem_gnt) begin
                        // The request was accepted with the old address, so its response must be dropped.
                        w_kill_nxt  = 1'b1;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end else if (i_imem_gnt) begin
                    w_state_nxt = S_WAIT;
                end else if (i_halt) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_WAIT: begin
                if (w_ctl) begin
                    w_pc_nxt = w_ctl_pc;
                    if (i_imem_rvalid) begin
                        // A response arriving in the same cycle is the stale one. Drop it and refetch now.
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_kill_nxt  = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end else if (i_imem_rvalid) begin
                    if (r_kill) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_HOLD: begin
                if (w_ctl) begin
                    w_pc_nxt    = w_ctl_pc;
                    w_state_nxt = S_REQ;
                end else if (i_dec_ready) begin
                    w_pc_nxt = r_pc + 32'd4;
                    if (i_halt) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HALT: begin
                if (w_ctl) begin
                    w_pc_nxt    = w_ctl_pc;
                    w_state_nxt = S_REQ;
                end else begin
                    w_state_nxt = S_HALT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pc_nxt    = RESET_ADDR;
                w_kill_nxt  = 1'b0;
            end
        endcase
    end

    // Fetch PC, kill flag, held instruction and misaligned pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc         <= RESET_ADDR;
            r_kill       <= 1'b0;
            r_inst       <= 32'd0;
            r_inst_pc    <= 32'd0;
            r_misaligned <= 1'b0;
        end else begin
            r_pc         <= w_pc_nxt;
            r_kill       <= w_kill_nxt;
            r_misaligned <= w_mis_evt;
            if (w_latch) begin
                r_inst    <= i_imem_rdata;
                r_inst_pc <= r_pc;
            end
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        o_imem_req   = 1'b0;
        o_inst_valid = 1'b0;
        o_halted     = 1'b0;
        case (r_state)
            S_REQ:   o_imem_req   = 1'b1;
            S_HOLD:  o_inst_valid = 1'b1;
            S_HALT:  o_halted     = 1'b1;
            default: o_imem_req   = 1'b0;
        endcase
    end

    assign o_imem_addr  = r_pc;
    assign o_inst       = r_inst;
    assign o_inst_pc    = r_inst_pc;
    assign o_misaligned = r_misaligned;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer. The bench acts as the instruction
// memory and as the decode stage. A reference model tracks which fetch
// address comes next and which responses must be delivered. Delivered
// instructions go into a scoreboard queue, and a separate monitor pops that
// queue whenever decode is presented with an instruction.
module tb_pc_sequencer;

    localparam logic [31:0] RST_A  = 32'h0000_0000;
    localparam logic [31:0] TRAP_V = 32'h0000_0100;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        i_dec_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_target;
    logic        i_trap;
    logic        i_halt;
    logic        o_misaligned;
    logic        o_halted;

    always #5 i_clk = ~i_clk;

    pc_sequencer #(.RESET_ADDR(RST_A), .TRAP_VECTOR(TRAP_V)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
        .i_dec_ready(i_dec_ready), .i_redirect(i_redirect), .i_redirect_target(i_redirect_target),
        .i_trap(i_trap), .i_halt(i_halt),
        .o_misaligned(o_misaligned), .o_halted(o_halted)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t sb_q[$];

    // Reference model state
    logic [31:0] m_pc;        // address of the next fetch
    logic        m_out;       // a granted fetch is waiting for its response
    logic        m_kill;      // that fetch was re-steered and must be dropped
    logic [31:0] m_out_addr;
    logic        m_inst;      // decode should currently see an instruction
    logic        m_halted;
    logic        m_mis;

    int unsigned p_trap, p_redir, p_halt, p_gnt, p_rv, p_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Monitor: each newly presented instruction must match the head of the scoreboard and stay stable while held
    logic mon_prev = 1'b0;
    exp_t mon_cur;
    always @(negedge i_clk) begin
        if (i_rst) begin
            mon_prev = 1'b0;
        end else begin
            if (o_inst_valid && !mon_prev) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_inst_valid", 32'd1, 32'd0);
                    mon_cur.pc   = o_inst_pc;
                    mon_cur.inst = o_inst;
                end else begin
                    mon_cur = sb_q.pop_front();
                    check("inst_pc", o_inst_pc, mon_cur.pc);
                    check("inst", o_inst, mon_cur.inst);
                end
            end else if (o_inst_valid) begin
                check("inst_stable", o_inst, mon_cur.inst);
                check("inst_pc_stable", o_inst_pc, mon_cur.pc);
            end
            mon_prev = o_inst_valid;
        end
    end

    task automatic do_reset(input int ncyc);
        @(negedge i_clk); #1;
        i_rst         = 1'b1;
        i_trap        = 1'b0;
        i_redirect    = 1'b0;
        i_halt        = 1'b0;
        i_imem_gnt    = 1'b0;
        i_dec_ready   = 1'b0;
        i_imem_rvalid = 1'b1;           // late response that must be ignored
        i_imem_rdata  = $urandom;
        repeat (ncyc) begin
            @(negedge i_clk); #1;
            check_bit("rst_imem_req", o_imem_req, 1'b0);
            check_bit("rst_inst_valid", o_inst_valid, 1'b0);
            check("rst_inst", o_inst, 32'd0);
            check("rst_inst_pc", o_inst_pc, 32'd0);
            check_bit("rst_misaligned", o_misaligned, 1'b0);
            check_bit("rst_halted", o_halted, 1'b0);
        end
        sb_q.delete();
        m_pc     = RST_A;
        m_out    = 1'b0;
        m_kill   = 1'b0;
        m_inst   = 1'b0;
        m_halted = 1'b0;
        m_mis    = 1'b0;
        // Release. The next edge is the IDLE cycle, and the stray rvalid is still high during it.
        i_rst = 1'b0;
    endtask

    task automatic step();
        logic        exp_req, trap, redir, ctl, mis, gnt, rv, rdy, was_inst;
        logic [31:0] tgt, tmp, newpc;
        logic [1:0]  lo;
        exp_t        e;
        @(negedge i_clk); #1;
        exp_req = !m_out && !m_inst && !m_halted;
        check_bit("imem_req", o_imem_req, exp_req);
        if (exp_req) check("imem_addr", o_imem_addr, m_pc);
        check_bit("inst_valid", o_inst_valid, m_inst);
        check_bit("halted", o_halted, m_halted);
        check_bit("misaligned", o_misaligned, m_mis);

        trap  = ($urandom_range(99) < p_trap);
        redir = ($urandom_range(99) < p_redir);
        tmp   = $urandom;
        case ($urandom_range(7))
            0: tgt = 32'hFFFF_FFFC;
            1: tgt = 32'h0000_0200;
            2: begin lo = 2'($urandom_range(3, 1)); tgt = {tmp[31:2], lo}; end
            default: tgt = {tmp[31:2], 2'b00};
        endcase
        if ($urandom_range(99) < p_halt) i_halt = ~i_halt;
        gnt = exp_req && ($urandom_range(99) < p_gnt);
        if (m_out) rv = ($urandom_range(99) < p_rv);
        else       rv = exp_req && !gnt && ($urandom_range(3) == 0);
        rdy = ($urandom_range(99) < p_rdy);

        i_trap            = trap;
        i_redirect        = redir;
        i_redirect_target = tgt;
        i_imem_gnt        = gnt;
        i_imem_rvalid     = rv;
        i_imem_rdata      = (m_out && rv) ? mem_word(m_out_addr) : $urandom;
        i_dec_ready       = rdy;

        // Model the effect of this cycle's inputs
        ctl      = trap | redir;
        mis      = !trap && redir && (tgt[1:0] != 2'b00);
        newpc    = (trap || tgt[1:0] != 2'b00) ? TRAP_V : tgt;
        m_mis    = mis;
        was_inst = m_inst;
        if (m_out && rv) begin
            if (!m_kill && !ctl) begin
                e.pc   = m_out_addr;
                e.inst = mem_word(m_out_addr);
                sb_q.push_back(e);
                m_inst = 1'b1;
            end
            m_out  = 1'b0;
            m_kill = 1'b0;
        end
        if (exp_req && gnt) begin
            m_out      = 1'b1;
            m_out_addr = m_pc;
            m_kill     = 1'b0;
        end else if (exp_req && !ctl && i_halt) begin
            m_halted = 1'b1;
        end
        if (ctl) begin
            m_pc     = newpc;
            if (m_out) m_kill = 1'b1;
            m_inst   = 1'b0;
            m_halted = 1'b0;
        end else if (was_inst && rdy) begin
            m_pc   = m_pc + 32'd4;
            m_inst = 1'b0;
            if (i_halt) m_halted = 1'b1;
        end
    endtask

    initial begin
        i_rst = 1'b1; i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 32'd0;
        i_dec_ready = 1'b0; i_redirect = 1'b0; i_redirect_target = 32'd0;
        i_trap = 1'b0; i_halt = 1'b0;

        // Ideal memory and decode: back-to-back sequential fetches
        p_trap = 0; p_redir = 0; p_halt = 0; p_gnt = 100; p_rv = 100; p_rdy = 100;
        do_reset(3);
        repeat (30) step();

        // Random control traffic and handshakes
        p_trap = 3; p_redir = 5; p_halt = 3; p_gnt = 60; p_rv = 40; p_rdy = 50;
        repeat (3000) step();

        // Resets at arbitrary points, including while a fetch is in flight
        repeat (6) begin
            do_reset(int'($urandom_range(3, 1)));
            repeat ($urandom_range(200, 5)) step();
        end

        // Slow decoder holding instructions for many cycles
        p_rdy = 10;
        repeat (500) step();

        // Frequent halts
        p_rdy = 50; p_halt = 20;
        repeat (1000) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
